spmv_result_collector: RTL and testbench
========================================

Name: spmv_result_collector

Overview:
- Downstream of the level-4 accumulate stage of the sparse matrix-vector pipeline.
- Each cycle it captures a bundle of 1..4 signed 28-bit row results and buffers them in a multi-write, single-read FIFO.
- It narrows each result to the output width and streams them out one per cycle with a valid/ready handshake, tagged with a running row index.
- The pipeline cannot stall, so the block signals almost-full and drops whole bundles on overflow.

Parameters:
- IN_W, 28, width of each incoming result lane
- OUT_W, 16, width of each emitted result
- DEPTH, 16, FIFO entries (one result each); power of two, >= 8
- ROW_W, 8, width of the row-index tag

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- clr  in  1  synchronous flush/frame restart
- res_valid  in  1  bundle strobe from level-4 stage
- res_data  in  4*IN_W  four results; lane0 = [4*IN_W-1 -: IN_W] is emitted first
- res_cnt  in  3  number of valid lanes, counted from lane0
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_W  narrowed head result
- out_row  out  ROW_W  row index of head result
- almost_full  out  1  free slots < 4
- overflow  out  1  sticky: a bundle was dropped
- level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0 at a clk edge): FIFO empty, read/write pointers 0, row counter 0, overflow 0.
  - Resulting outputs: out_valid=0, level=0, almost_full=0, out_data=0, out_row=0.
  - Reset mid-stream discards all contents; no partial bundle survives.
- clr=1: same effect as reset at that edge. It has priority over any simultaneous push or pop in that cycle.
- Push:
  - A push occurs when res_valid=1 and eff_cnt>0.
  - eff_cnt = res_cnt, except values 5..7 are clamped to 4.
  - Accept condition: (DEPTH - level) >= eff_cnt, evaluated on the pre-edge level. A same-cycle pop is not credited.
  - If accepted, lanes 0..eff_cnt-1 are written at wr_ptr, wr_ptr+1, ... modulo DEPTH, and wr_ptr advances by eff_cnt.
  - If rejected, nothing is written and overflow sets. overflow stays set until rst or clr.
  - res_valid=1 with res_cnt=0 is a no-op and does not set overflow.
- Pop:
  - Handshake occurs when out_valid and out_ready. rd_ptr then advances by 1 and the row counter increments, wrapping at 2^ROW_W.
  - out_valid holds and out_data/out_row stay stable while out_ready=0.
- Simultaneous push and pop: level_next = level + eff_cnt(accepted) - pop. Pointers wrap independently.
- Timing and status:
  - Storage is first-word-fall-through.
  - Data pushed at edge N is visible on out_data in the cycle after edge N. Latency is 1 cycle.
  - out_valid = (level != 0).
  - almost_full = (DEPTH - level) < 4, combinational from level.
- out_row is the row-counter value at the time the head is presented (first result after reset or clr = row 0).
- Arithmetic:
  - Results are signed two's complement.
  - If OUT_W >= IN_W, sign-extend.
  - Otherwise apply the narrowing rule (see Optional Feature).
  - Narrowing is applied on the read side; storage holds full IN_W.

Optional Feature:
- Macro: SPMV_OUT_SAT_EN.
- Defined: results outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] clamp to the nearest bound.
- Undefined: out_data takes the low OUT_W bits (wrap-around), and no saturation logic is synthesised.

Decomposition:
- Package spmv_pkg holds:
  - lane count (4) and default IN_W
  - res_cnt clamp constant
  - narrowing function with the sat/wrap variants
- One sub-module: spmv_narrow (combinational IN_W -> OUT_W sign-extend/saturate/truncate). It is instantiated on the FIFO head.

Test Plan:
1. After reset, push bundle res_cnt=3, lanes {5, -7, 300}, out_ready=1 -> outputs 5, -7, 300 on three consecutive cycles with out_row 0, 1, 2; level returns to 0.
2. Push 4, 4, 4 with out_ready=0 (DEPTH=16) -> level=12, almost_full=0; a further push of 4 -> level=16, almost_full=1; next push of 1 -> dropped, overflow=1, level stays 16.
3. Same cycle: level=14, push res_cnt=2 and pop -> push accepted (14+2<=16), level=15, head advances by 1.
4. Lane value 40000 with OUT_W=16 -> out_data=32767 with SPMV_OUT_SAT_EN defined; 0x9C40 (wrap) without it. Lane -40000 -> -32768 when saturating.
5. Fill to 10, assert clr together with res_valid (res_cnt=2) -> level=0, out_valid=0, overflow=0, out_row restarts at 0 on the next pushed result.
6. Stream 300 single results with out_ready=1 -> out_row wraps 255 -> 0 (ROW_W=8); assert rst mid-stream -> all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared constants and helpers for the SpMV result collector.
// Build option: SPMV_OUT_SAT_EN selects saturating narrowing instead of wrap-around.
package spmv_pkg;

    localparam int          LANES    = 4;
    localparam int          DEF_IN_W = 28;
    localparam logic [2:0]  CNT_MAX  = 3'd4;

    // Lane counts above the bundle width are treated as a full bundle.
    function automatic logic [2:0] clamp_cnt(input logic [2:0] cnt);
        return (cnt > CNT_MAX) ? CNT_MAX : cnt;
    endfunction

`ifdef SPMV_OUT_SAT_EN
    function automatic logic signed [63:0] narrow_fn(input logic signed [63:0] x,
                                                     input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction
`else
    // Wrap variant: the caller keeps only the low bits.
    function automatic logic signed [63:0] narrow_fn(input logic signed [63:0] x);
        return x;
    endfunction
`endif

endpackage

// File: rtl/spmv_narrow.sv
// Combinational IN_W -> OUT_W conversion of one signed result.
// Sign-extends when widening; SPMV_OUT_SAT_EN selects saturate, otherwise truncate.
module spmv_narrow
    import spmv_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    generate
        if (OUT_W >= IN_W) begin : g_ext
            assign dout = OUT_W'($signed(din));
        end else begin : g_narrow
            logic signed [63:0] wide;
            logic [63-OUT_W:0]  unused_hi;
            assign wide = 64'($signed(din));
`ifdef SPMV_OUT_SAT_EN
            assign {unused_hi, dout} = narrow_fn(wide, OUT_W);
`else
            assign {unused_hi, dout} = narrow_fn(wide);
`endif
        end
    endgenerate

endmodule

// File: rtl/spmv_result_collector.sv
// Multi-write / single-read FWFT FIFO collecting 1..4 row results per cycle and
// streaming them out narrowed and row-tagged. Build option: SPMV_OUT_SAT_EN.
module spmv_result_collector
    import spmv_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = 16,
    parameter int DEPTH = 16,
    parameter int ROW_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       res_valid,
    input  logic [LANES*IN_W-1:0]      res_data,
    input  logic [2:0]                 res_cnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [ROW_W-1:0]           out_row,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [IN_W-1:0]  mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             ovf_q, ovf_d;

    logic [2:0]       eff_cnt;
    logic [LW-1:0]    free;
    logic             push_req;
    logic             accept;
    logic             pop;
    logic [OUT_W-1:0] head_narrow;

    always_comb begin
        eff_cnt  = clamp_cnt(res_cnt);
        free     = LW'(DEPTH) - level_q;
        push_req = res_valid && (eff_cnt != 3'd0);
        // Acceptance uses pre-edge occupancy; a same-cycle pop frees nothing yet.
        accept   = push_req && (free >= LW'(eff_cnt));
        pop      = (level_q != '0) && out_ready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        row_d    = row_q;
        ovf_d    = ovf_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            row_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    if (3'(i) < eff_cnt) begin
                        mem_d[wr_ptr_q + PW'(i)] = res_data[(LANES-i)*IN_W-1 -: IN_W];
                    end
                end
                wr_ptr_d = wr_ptr_q + PW'(eff_cnt);
            end
            if (push_req && !accept) begin
                ovf_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                row_d    = row_q + ROW_W'(1);
            end
            level_d = level_q + (accept ? LW'(eff_cnt) : LW'(0)) - (pop ? LW'(1) : LW'(0));
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            row_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            row_q    <= row_d;
            ovf_q    <= ovf_d;
        end
    end

    spmv_narrow #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_narrow (
        .din  (mem_q[rd_ptr_q]),
        .dout (head_narrow)
    );

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign out_valid   = (level_q != '0);
    assign out_data    = out_valid ? head_narrow : '0;
    assign out_row     = row_q;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign almost_full = (free < LW'(4));

endmodule

// File: tb/tb_spmv_result_collector.sv
// Directed, table-driven bench for spmv_result_collector (default parameters).
// Expected narrowing results follow SPMV_OUT_SAT_EN when the bench is built with it.
module tb_spmv_result_collector;

    localparam int IN_W  = 28;
    localparam int OUT_W = 16;
    localparam int DEPTH = 16;
    localparam int ROW_W = 8;
    localparam int LW    = 5;

`ifdef SPMV_OUT_SAT_EN
    localparam int EXP_POS = 32'h7FFF;
    localparam int EXP_NEG = 32'h8000;
`else
    localparam int EXP_POS = 32'h9C40;
    localparam int EXP_NEG = 32'h63C0;
`endif

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              res_valid;
    logic [4*IN_W-1:0] res_data;
    logic [2:0]        res_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [ROW_W-1:0]  out_row;
    logic              almost_full;
    logic              overflow;
    logic [LW-1:0]     level;

    always #5 clk = ~clk;

    spmv_result_collector #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .ROW_W (ROW_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_cnt     (res_cnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .almost_full (almost_full),
        .overflow    (overflow),
        .level       (level)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       clr;
        logic       rv;
        logic [2:0] cnt;
        int         d0, d1, d2, d3;
        logic       rdy;
        int         e_valid;
        int         e_data;
        int         e_row;
        int         e_level;
        int         e_af;
        int         e_ov;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic rst_n, input logic c, input logic rv,
                                input logic [2:0] cnt, input int d0, input int d1,
                                input int d2, input int d3, input logic rdy,
                                input int ev, input int ed, input int er,
                                input int el, input int eaf, input int eov);
        vec_t v;
        v.rst_n = rst_n; v.clr = c; v.rv = rv; v.cnt = cnt;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed & 32'hFFFF; v.e_row = er;
        v.e_level = el; v.e_af = eaf; v.e_ov = eov;
        vecs.push_back(v);
    endfunction

    function automatic logic [4*IN_W-1:0] pack(input int d0, input int d1,
                                               input int d2, input int d3);
        return {IN_W'(d0), IN_W'(d1), IN_W'(d2), IN_W'(d3)};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL step%0d %s got=0x%0h exp=0x%0h", idx, name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst_n, input logic c, input logic rv,
                         input logic [2:0] cnt, input logic [4*IN_W-1:0] d,
                         input logic rdy);
        rst       = rst_n;
        clr       = c;
        res_valid = rv;
        res_cnt   = cnt;
        res_data  = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input int ev, input int ed, input int er,
                             input int el, input int eaf, input int eov);
        chk("out_valid",   idx, int'(out_valid),   ev);
        chk("out_data",    idx, int'(out_data),    ed & 32'hFFFF);
        chk("out_row",     idx, int'(out_row),     er);
        chk("level",       idx, int'(level),       el);
        chk("almost_full", idx, int'(almost_full), eaf);
        chk("overflow",    idx, int'(overflow),    eov);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; res_valid = 1'b0; res_cnt = '0;
        res_data = '0; out_ready = 1'b0;

        // Reset, then a 3-lane bundle drained with ready held high.
        add(0,0,0,0,  0,0,0,0, 0,  0,0,0,0,0,0);
        add(1,0,1,3,  5,-7,300,0, 1,  1,5,0,3,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  1,-7,1,2,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  1,300,2,1,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  0,0,3,0,0,0);
        // Fill to full without draining; the next bundle is dropped.
        add(1,1,0,0,  0,0,0,0, 0,  0,0,0,0,0,0);
        add(1,0,1,4,  1,2,3,4, 0,  1,1,0,4,0,0);
        add(1,0,1,4,  5,6,7,8, 0,  1,1,0,8,0,0);
        add(1,0,1,4,  9,10,11,12, 0,  1,1,0,12,0,0);
        add(1,0,1,4,  13,14,15,16, 0,  1,1,0,16,1,0);
        add(1,0,1,1,  99,0,0,0, 0,  1,1,0,16,1,1);
        // Drain to 14, push 2 with a pop (fits), then push 2 at 15 (does not fit).
        add(1,0,0,0,  0,0,0,0, 1,  1,2,1,15,1,1);
        add(1,0,0,0,  0,0,0,0, 1,  1,3,2,14,1,1);
        add(1,0,1,2,  17,18,0,0, 1,  1,4,3,15,1,1);
        add(1,0,1,2,  19,20,0,0, 1,  1,5,4,14,1,1);
        // clr beats a simultaneous push/pop; cnt 7 clamps to 4; cnt 0 is a no-op.
        add(1,1,1,2,  50,51,0,0, 1,  0,0,0,0,0,0);
        add(1,0,1,7,  21,22,23,24, 0,  1,21,0,4,0,0);
        add(1,0,1,0,  77,78,79,80, 0,  1,21,0,4,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  1,22,1,3,0,0);
        // Narrowing of out-of-range and exact-bound values.
        add(1,1,0,0,  0,0,0,0, 0,  0,0,0,0,0,0);
        add(1,0,1,4,  40000,-40000,32767,-32768, 0,  1,EXP_POS,0,4,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  1,EXP_NEG,1,3,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  1,32'h7FFF,2,2,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  1,32'h8000,3,1,0,0);
        add(1,0,0,0,  0,0,0,0, 1,  0,0,4,0,0,0);

        foreach (vecs[k]) begin
            drive(vecs[k].rst_n, vecs[k].clr, vecs[k].rv, vecs[k].cnt,
                  pack(vecs[k].d0, vecs[k].d1, vecs[k].d2, vecs[k].d3), vecs[k].rdy);
            check_all(k, vecs[k].e_valid, vecs[k].e_data, vecs[k].e_row,
                      vecs[k].e_level, vecs[k].e_af, vecs[k].e_ov);
        end

        // Streaming single results: row tag wraps past 255, pointers wrap many times.
        drive(1, 1, 0, 0, '0, 0);
        for (int j = 0; j < 300; j++) begin
            drive(1, 0, 1, 1, pack(j, 0, 0, 0), 1);
            chk("stream_data",  1000 + j, int'(out_data),  j);
            chk("stream_row",   1000 + j, int'(out_row),   j % 256);
            chk("stream_level", 1000 + j, int'(level),     1);
        end

        // Reset mid-stream with a bundle on the input: nothing may survive.
        drive(0, 0, 1, 4, pack(1, 2, 3, 4), 1);
        check_all(2000, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, '0, 1);
        check_all(2001, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
